as5600_i2c_target: RTL and testbench
====================================

// Module: as5600_i2c_target
// PURPOSE
//  I2C target (responder) emulating the AS5600 magnetic encoder, i.e. the far end of the
//  subsystem's I2C angle-read master. Serves STATUS/RAW ANGLE/ANGLE registers from a
//  parallel 12-bit angle input so swerve-module control loops run against a simulated or
//  HIL-driven wheel angle. Oversamples SCL/SDA on the system clock; open-drain SDA only.
// PARAMETERS
//  DEV_ADDR     7'h36  7-bit target address matched in the address byte
//  FILT_CYC     3      consecutive equal samples required to accept an SCL/SDA level change
// PORTS
//  clock        in   1   system clock (>= 16x SCL frequency)
//  reset        in   1   synchronous, active-high reset
//  scl_in       in   1   I2C clock from bus (async)
//  sda_in       in   1   I2C data from bus (async)
//  sda_oe       out  1   1 = pull SDA low; 0 = release (pad is open-drain)
//  raw_angle    in   12  angle value to present, 0..4095
//  magnet_det   in   1   reported as STATUS.MD
//  busy         out  1   1 from accepted START+address match until STOP/NACK/mismatch
//  rd_done      out  1   1-cycle pulse when master NACKs a read byte (read transfer end)
//  ptr          out  8   current register pointer
// BEHAVIOUR
//  - Reset: sda_oe=0, busy=0, rd_done=0, ptr=8'h00, state=IDLE, snapshot=0, filters load 1.
//  - Input path: 2-FF sync then FILT_CYC filter; edges taken on filtered signals only.
//  - START = SDA fall while SCL high; STOP = SDA rise while SCL high. Detected in ANY state:
//    START -> ADDR (repeated start legal), STOP -> IDLE with sda_oe released same cycle.
//  - Data sampled on filtered SCL rise; sda_oe changes only on filtered SCL fall (+1 clk).
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
//  - ADDR: shift 8 bits MSB first. addr[7:1]==DEV_ADDR -> ADDR_ACK, else WAIT_STOP (no drive).
//  - ADDR_ACK: sda_oe=1 from fall after bit 8 to next fall. R/W=0 -> PTR; R/W=1 -> snapshot
//    raw_angle/magnet_det at ACK-start, load byte at ptr, -> RDATA.
//  - PTR: 8 bits -> ptr; ACK; -> WDATA. WDATA: byte written at ptr (see CONFIGURATION),
//    ACK, ptr+1, repeat. ptr wraps 8'hFF -> 8'h00.
//  - RDATA: drive sda_oe=~bit[7-n] each fall, release after bit 8. RACK samples master bit:
//    0 (ACK) -> ptr+1, load next byte, RDATA; 1 (NACK) -> rd_done pulse, ptr+1, WAIT_STOP.
//  - Snapshot taken once per read transfer: multi-byte reads are coherent even if
//    raw_angle changes mid-transfer; new value only after a fresh START+read address.
//  - Register map (read): 8'h0B={2'b0,magnet_det,5'b0}; 8'h0C={4'b0,raw[11:8]};
//    8'h0D=raw[7:0]; 8'h0E/8'h0F=ANGLE hi/lo same format; all other addresses read 8'h00.
//  - Writes to non-writable addresses: ACKed, data discarded, ptr still increments.
//  - ptr retained across STOP (read without pointer write continues from last ptr).
//  - Never stretches SCL; never drives SDA high.
// CONFIGURATION
//  AS5600_ZPOS_EN defined: ZPOS at 8'h01 {4'b0,zpos[11:8]} / 8'h02 zpos[7:0] writable and
//    readable (reset 12'h000); ANGLE = (raw_angle - zpos) mod 4096 (12-bit wrap subtract).
//  Not defined: 8'h01/8'h02 read 8'h00, writes discarded; ANGLE = raw_angle.
// TESTING
//  1 Write ptr 0x0C, rep-START, read 2 bytes ACK/NACK, raw=12'hABC -> 0x0A,0xBC; rd_done once.
//  2 Address 0x37 read -> sda_oe never asserted, busy=0, ptr unchanged.
//  3 raw changes 12'h123->12'h456 between byte 1 and 2 of a read -> bytes 0x01,0x23.
//  4 ptr=0xFF read 2 bytes -> 0x00 (0xFF unmapped) then reg 0x00, ptr ends 8'h01.
//  5 STOP mid-RDATA with bit=0 driven -> sda_oe=0 within 1 clk of STOP; state IDLE.
//  6 ZPOS_EN: write 0x01=0x01,0x02=0x00, raw=12'h080 -> ANGLE reads 0x0F,0x80; w/o -> 0x00,0x80.

Source files
------------

// File: rtl/as5600_i2c_target.sv
// AS5600-style I2C target serving STATUS / RAW ANGLE / ANGLE from a parallel angle input.
// SCL and SDA are synchronised and glitch-filtered; all bus decisions use filtered edges.
// Optional feature: define AS5600_ZPOS_EN to add the writable ZPOS register (0x01/0x02)
// and report ANGLE = raw_angle - zpos (12-bit wrap).
// Handshake: the bus is the only interface; sda_oe only ever pulls low (open drain),
// changes one clock after a filtered SCL fall (or on START/STOP), and SCL is never held.
// dbg_state exposes the FSM state (IDLE encodes as 0).
module as5600_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h36,
  parameter int         FILT_CYC = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] raw_angle,
  input  logic        magnet_det,
  output logic        busy,
  output logic        rd_done,
  output logic [7:0]  ptr,
  output logic [3:0]  dbg_state
);
  localparam int CW = (FILT_CYC < 2) ? 1 : $clog2(FILT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT_STOP
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]    r_s1, r_s2, r_f, r_fd;
  logic [CW-1:0] r_cnt [2];

  // two-flop synchroniser plus a level filter needing FILT_CYC agreeing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 2'b11; r_s2 <= 2'b11; r_f <= 2'b11; r_fd <= 2'b11;
      r_cnt[0] <= '0; r_cnt[1] <= '0;
    end else begin
      r_s1 <= {sda_in, scl_in};
      r_s2 <= r_s1;
      r_fd <= r_f;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_f[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(FILT_CYC - 1)) begin
          r_f[i]   <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_sda      = r_f[1];
  assign w_scl_rise = r_f[0] & ~r_fd[0];
  assign w_scl_fall = ~r_f[0] & r_fd[0];
  assign w_start    = r_f[0] & r_fd[0] & r_fd[1] & ~r_f[1];
  assign w_stop     = r_f[0] & r_fd[0] & ~r_fd[1] & r_f[1];

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_shift, w_shift_nxt, r_ptr, w_ptr_nxt, r_tx, w_tx_nxt;
  logic [3:0]  r_bitcnt, w_bitcnt_nxt;
  logic        r_oe, w_oe_nxt, r_busy, w_busy_nxt, r_rd_done, w_rd_done_nxt;
  logic        r_rw, w_rw_nxt, r_snap_md, w_snap_md_nxt;
  logic [11:0] r_snap_raw, w_snap_raw_nxt, w_angle;
  logic [7:0]  w_rd_addr, w_rd_byte;

`ifdef AS5600_ZPOS_EN
  logic [11:0] r_zpos;
  logic        w_wr_en;
  assign w_angle = r_snap_raw - r_zpos;
`else
  assign w_angle = r_snap_raw;
`endif

  // RACK loads the byte after the current pointer; ADDR_ACK loads the current one
  assign w_rd_addr = (r_state == S_RACK) ? r_ptr + 8'd1 : r_ptr;

  // read register map, served from the per-transfer snapshot
  always_comb begin
    w_rd_byte = 8'h00;
    case (w_rd_addr)
      8'h0B: w_rd_byte = {2'b00, r_snap_md, 5'b00000};
      8'h0C: w_rd_byte = {4'h0, r_snap_raw[11:8]};
      8'h0D: w_rd_byte = r_snap_raw[7:0];
      8'h0E: w_rd_byte = {4'h0, w_angle[11:8]};
      8'h0F: w_rd_byte = w_angle[7:0];
`ifdef AS5600_ZPOS_EN
      8'h01: w_rd_byte = {4'h0, r_zpos[11:8]};
      8'h02: w_rd_byte = r_zpos[7:0];
`endif
      default: w_rd_byte = 8'h00;
    endcase
  end

  // protocol FSM: next state and next datapath values
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bitcnt_nxt   = r_bitcnt;
    w_ptr_nxt      = r_ptr;
    w_tx_nxt       = r_tx;
    w_oe_nxt       = r_oe;
    w_busy_nxt     = r_busy;
    w_rd_done_nxt  = 1'b0;
    w_rw_nxt       = r_rw;
    w_snap_raw_nxt = r_snap_raw;
    w_snap_md_nxt  = r_snap_md;
`ifdef AS5600_ZPOS_EN
    w_wr_en        = 1'b0;
`endif
    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_bitcnt_nxt = '0;
      w_oe_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_bitcnt_nxt = '0;
            w_oe_nxt     = 1'b1;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == DEV_ADDR) begin
                w_state_nxt = S_ADDR_ACK;
                w_busy_nxt  = 1'b1;
                w_rw_nxt    = r_shift[0];
                if (r_shift[0]) begin
                  w_snap_raw_nxt = raw_angle;
                  w_snap_md_nxt  = magnet_det;
                end
              end else begin
                w_state_nxt = S_WAIT_STOP;
                w_busy_nxt  = 1'b0;
                w_oe_nxt    = 1'b0;
              end
            end else if (r_state == S_PTR) begin
              w_ptr_nxt   = r_shift;
              w_state_nxt = S_PTR_ACK;
            end else begin
              w_state_nxt = S_WDATA_ACK;
`ifdef AS5600_ZPOS_EN
              w_wr_en     = 1'b1;
`endif
            end
          end
        end
        S_ADDR_ACK: if (w_scl_fall) begin
          w_bitcnt_nxt = '0;
          if (r_rw) begin
            w_state_nxt = S_RDATA;
            w_tx_nxt    = w_rd_byte;
            w_oe_nxt    = ~w_rd_byte[7];
          end else begin
            w_state_nxt = S_PTR;
            w_oe_nxt    = 1'b0;
          end
        end
        S_PTR_ACK: if (w_scl_fall) begin
          w_state_nxt = S_WDATA;
          w_oe_nxt    = 1'b0;
        end
        S_WDATA_ACK: if (w_scl_fall) begin
          w_state_nxt = S_WDATA;
          w_oe_nxt    = 1'b0;
          w_ptr_nxt   = r_ptr + 8'd1;
        end
        S_RDATA: if (w_scl_fall) begin
          if (r_bitcnt == 4'd7) begin
            w_state_nxt  = S_RACK;
            w_oe_nxt     = 1'b0;
            w_bitcnt_nxt = '0;
          end else begin
            w_tx_nxt     = {r_tx[6:0], r_tx[7]};
            w_oe_nxt     = ~r_tx[6];
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end
        end
        S_RACK: begin
          if (w_scl_rise && w_sda) begin
            w_rd_done_nxt = 1'b1;
            w_ptr_nxt     = r_ptr + 8'd1;
            w_state_nxt   = S_WAIT_STOP;
            w_busy_nxt    = 1'b0;
          end else if (w_scl_fall) begin
            w_ptr_nxt    = r_ptr + 8'd1;
            w_tx_nxt     = w_rd_byte;
            w_oe_nxt     = ~w_rd_byte[7];
            w_state_nxt  = S_RDATA;
            w_bitcnt_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE; r_shift <= '0; r_bitcnt <= '0; r_ptr <= 8'h00; r_tx <= '0;
      r_oe <= 1'b0; r_busy <= 1'b0; r_rd_done <= 1'b0; r_rw <= 1'b0;
      r_snap_raw <= '0; r_snap_md <= 1'b0;
    end else begin
      r_state <= w_state_nxt; r_shift <= w_shift_nxt; r_bitcnt <= w_bitcnt_nxt;
      r_ptr <= w_ptr_nxt; r_tx <= w_tx_nxt; r_oe <= w_oe_nxt; r_busy <= w_busy_nxt;
      r_rd_done <= w_rd_done_nxt; r_rw <= w_rw_nxt;
      r_snap_raw <= w_snap_raw_nxt; r_snap_md <= w_snap_md_nxt;
    end
  end

`ifdef AS5600_ZPOS_EN
  // ZPOS register write on completion of a data byte addressed at 0x01/0x02
  always_ff @(posedge clock) begin
    if (reset) r_zpos <= 12'h000;
    else if (w_wr_en) begin
      if (r_ptr == 8'h01) r_zpos[11:8] <= r_shift[3:0];
      else if (r_ptr == 8'h02) r_zpos[7:0] <= r_shift;
    end
  end
`endif

  assign sda_oe    = r_oe;
  assign busy      = r_busy;
  assign rd_done   = r_rd_done;
  assign ptr       = r_ptr;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_as5600_i2c_target.sv
// Bench for as5600_i2c_target: a bit-banged I2C master, a register-map reference model
// and a scoreboard monitor comparing every byte read back against the expected queue.
module tb_as5600_i2c_target;
  localparam int Q = 8;  // clocks per quarter SCL period

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m_scl = 1'b1, m_sda = 1'b1, ovr = 1'b0;
  logic [11:0] raw_angle = 12'h000;
  logic        magnet_det = 1'b0;
  logic        scl_in, sda_in, sda_oe, busy, rd_done;
  logic [7:0]  ptr;
  logic [3:0]  dbg_state;

  assign scl_in = m_scl;
  // wired-AND bus; ovr lets the master force the line high over the target
  assign sda_in = m_sda & ~(sda_oe & ~ovr);

  always #5 clock = ~clock;

  as5600_i2c_target dut (
    .clock(clock), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .raw_angle(raw_angle), .magnet_det(magnet_det), .busy(busy), .rd_done(rd_done),
    .ptr(ptr), .dbg_state(dbg_state)
  );

  int          n_tests = 0, n_fail = 0;
  logic [7:0]  exp_q[$];
  logic        obs_valid = 1'b0;
  logic [7:0]  obs_byte = 8'h00;
  int          rd_cnt = 0;
  bit          oe_seen = 1'b0;
  int          m_ptr = 0;
  int          m_snap_raw = 0;
  bit          m_snap_md = 1'b0;
`ifdef AS5600_ZPOS_EN
  int          m_zpos = 0;
`endif

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // scoreboard monitor: compares every byte the master collects, tracks rd_done/sda_oe
  always @(posedge clock) begin
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rd_byte: got 0x%0h with nothing expected", obs_byte);
      end else chk("rd_byte", obs_byte, exp_q.pop_front());
    end
    if (rd_done) rd_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  // register map as the master sees it, from the values captured at the read address
  function automatic int model_reg(input int a);
    int ang;
`ifdef AS5600_ZPOS_EN
    ang = (m_snap_raw - m_zpos + 4096) % 4096;
`else
    ang = m_snap_raw;
`endif
    case (a)
      'h0B: return m_snap_md ? 'h20 : 'h00;
      'h0C: return m_snap_raw / 256;
      'h0D: return m_snap_raw % 256;
      'h0E: return ang / 256;
      'h0F: return ang % 256;
`ifdef AS5600_ZPOS_EN
      'h01: return m_zpos / 256;
      'h02: return m_zpos % 256;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic wq(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(Q); m_scl = 1'b1; wq(Q); m_sda = 1'b0; wq(Q); m_scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(Q); m_scl = 1'b1; wq(Q); m_sda = 1'b1; wq(Q);
  endtask

  task automatic send_bit(input bit b);
    m_sda = b; wq(Q); m_scl = 1'b1; wq(2 * Q); m_scl = 1'b0; wq(Q);
  endtask

  task automatic read_bit(output bit b);
    m_sda = 1'b1; wq(Q); m_scl = 1'b1; wq(Q); b = sda_in; wq(Q); m_scl = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input bit nack);
    bit b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n,
                          input logic [7:0] d0, input logic [7:0] d1, input bit stop);
    bit ack;
    bit match;
    logic [7:0] dv;
    match = (a == 7'h36);
    i2c_start();
    write_byte({a, 1'b0}, ack);
    chk("wr_addr_ack", ack, match ? 0 : 1);
    chk("wr_busy", busy, match ? 1 : 0);
    if (match) begin
      write_byte(p, ack);
      chk("ptr_ack", ack, 0);
      m_ptr = p;
      for (int i = 0; i < n; i++) begin
        dv = (i == 0) ? d0 : d1;
        write_byte(dv, ack);
        chk("wdata_ack", ack, 0);
`ifdef AS5600_ZPOS_EN
        if (m_ptr == 1) m_zpos = (m_zpos % 256) + (dv % 16) * 256;
        if (m_ptr == 2) m_zpos = (m_zpos / 256) * 256 + dv;
`endif
        m_ptr = (m_ptr + 1) % 256;
      end
    end
    if (stop || !match) i2c_stop();
    chk("wr_ptr", ptr, m_ptr);
  endtask

  task automatic do_read(input logic [6:0] a, input int n, input bit chg, input logic [11:0] raw2);
    bit ack;
    bit match;
    logic [7:0] d;
    int rd0;
    match = (a == 7'h36);
    rd0 = rd_cnt;
    i2c_start();
    write_byte({a, 1'b1}, ack);
    chk("rd_addr_ack", ack, match ? 0 : 1);
    chk("rd_busy", busy, match ? 1 : 0);
    if (match) begin
      m_snap_raw = raw_angle;
      m_snap_md  = magnet_det;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(8'(model_reg(m_ptr)));
        read_byte(d, i == n - 1);
        obs_byte = d; obs_valid = 1'b1; wq(1); obs_valid = 1'b0;
        m_ptr = (m_ptr + 1) % 256;
        if (chg && i == 0) raw_angle = raw2;
      end
    end
    i2c_stop();
    wq(2);
    chk("rd_done_cnt", rd_cnt - rd0, match ? 1 : 0);
    chk("rd_ptr", ptr, m_ptr);
    chk("busy_after_stop", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ack;
    int c, pick;
    logic [7:0] p;
    logic [7:0] ptbl [6];
    ptbl[0] = 8'h0B; ptbl[1] = 8'h0C; ptbl[2] = 8'h0D;
    ptbl[3] = 8'h0E; ptbl[4] = 8'h0F; ptbl[5] = 8'h01;

    wq(5); reset = 1'b0; wq(2);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_state", dbg_state, 0);

    // pointer write, repeated START, two-byte read of RAW ANGLE
    raw_angle = 12'hABC;
    do_write(7'h36, 8'h0C, 0, 8'h00, 8'h00, 1'b0);
    do_read(7'h36, 2, 1'b0, 12'h000);

    // foreign address: no drive at all, pointer untouched
    oe_seen = 1'b0;
    do_read(7'h37, 0, 1'b0, 12'h000);
    chk("foreign_oe_seen", oe_seen, 0);

    // angle changes mid-transfer: bytes stay coherent, next transfer sees the new value
    raw_angle = 12'h123;
    do_write(7'h36, 8'h0C, 0, 8'h00, 8'h00, 1'b1);
    do_read(7'h36, 2, 1'b1, 12'h456);
    do_write(7'h36, 8'h0C, 0, 8'h00, 8'h00, 1'b1);
    do_read(7'h36, 1, 1'b0, 12'h000);

    // pointer wrap from 0xFF
    do_write(7'h36, 8'hFF, 0, 8'h00, 8'h00, 1'b1);
    do_read(7'h36, 2, 1'b0, 12'h000);

    // STOP forced while the target is driving a 0 data bit
    raw_angle = 12'hABC;
    do_write(7'h36, 8'h0C, 0, 8'h00, 8'h00, 1'b1);
    i2c_start();
    write_byte({7'h36, 1'b1}, ack);
    chk("t5_addr_ack", ack, 0);
    chk("t5_oe_drive", sda_oe, 1);
    ovr = 1'b1; m_sda = 1'b0; wq(Q); m_scl = 1'b1; wq(Q); m_sda = 1'b1;
    c = 0;
    while (sda_oe && c < 20) begin wq(1); c++; end
    chk("t5_release_cycles_le6", (c <= 6) ? 1 : 0, 1);
    wq(2);
    chk("t5_state_idle", dbg_state, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ptr", ptr, m_ptr);
    ovr = 1'b0; wq(Q);

    // ZPOS write and ANGLE readback (both builds), plus STATUS
    do_write(7'h36, 8'h01, 2, 8'h01, 8'h00, 1'b1);
    raw_angle = 12'h080;
    do_write(7'h36, 8'h0E, 0, 8'h00, 8'h00, 1'b1);
    do_read(7'h36, 2, 1'b0, 12'h000);
    do_write(7'h36, 8'h01, 0, 8'h00, 8'h00, 1'b0);
    do_read(7'h36, 2, 1'b0, 12'h000);
    magnet_det = 1'b1;
    do_write(7'h36, 8'h0B, 0, 8'h00, 8'h00, 1'b1);
    do_read(7'h36, 1, 1'b0, 12'h000);

    // randomized transfers
    for (int k = 0; k < 8; k++) begin
      raw_angle  = 12'($urandom_range(0, 4095));
      magnet_det = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        do_write(7'h36, 8'h01, 2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
      pick = $urandom_range(0, 7);
      p = (pick < 6) ? ptbl[pick] : 8'($urandom_range(0, 255));
      do_write(7'h36, p, 0, 8'h00, 8'h00, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) do_read(7'($urandom_range(0, 53)), 0, 1'b0, 12'h000);
      else do_read(7'h36, $urandom_range(1, 3), 1'b0, 12'h000);
    end

    wq(4);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
